park_slot_controller: RTL and testbench

//  Sequencer and owner of the parking-lot slot resource. Serves entry and exit requests
//  one at a time. On entry, allocates the lowest free slot and issues token = slot ^ pattern.
//  On exit, drives the decrypt datapath (token, pattern -> park_number) and releases that slot.

---
 rtl/park_slot_controller_if.sv | 22 ++
 rtl/park_slot_controller.sv | 138 +++++++++++++
 tb/tb_park_slot_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/park_slot_controller_if.sv
// Gate/keypad handshake bundle for the parking-lot slot controller.
// The gate side (master) raises level requests; the controller (slave) answers with one-cycle pulses.
interface park_slot_controller_if;
    logic       entry_req;
    logic       exit_req;
    logic [2:0] exit_token;
    logic       entry_grant;
    logic       entry_deny;
    logic [2:0] token_out;
    logic       exit_ack;
    logic       exit_err;

    modport master (
        output entry_req, exit_req, exit_token,
        input  entry_grant, entry_deny, token_out, exit_ack, exit_err
    );

    modport slave (
        input  entry_req, exit_req, exit_token,
        output entry_grant, entry_deny, token_out, exit_ack, exit_err
    );
endinterface

// File: rtl/park_slot_controller.sv
// Parking-lot slot sequencer: owns the 8-slot occupancy map, issues tokens on entry,
// and validates exit tokens through an external decrypt block.
module park_slot_controller #(
    parameter logic [2:0] PATTERN_SEED = 3'b101,
    parameter bit         EXIT_FIRST   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    park_slot_controller_if.slave gate,
    output logic                  dec_exit,
    output logic [2:0]            dec_token,
    output logic [2:0]            dec_pattern,
    input  logic [2:0]            dec_park_number,
    output logic [7:0]            occupancy,
    output logic [3:0]            free_count,
    output logic                  full
);

    typedef enum logic [2:0] {IDLE, ALLOC, DECODE, RESP, WAIT_REL} state_t;
    typedef enum logic [1:0] {RES_GRANT, RES_DENY, RES_ACK, RES_ERR} result_t;

    state_t     state, next_state;
    result_t    result, result_next;
    logic       pick_exit;
    logic       serve_exit;
    logic [2:0] pattern, pattern_next;
    logic [2:0] free_idx;
    logic [7:0] occ_next;
    logic [3:0] free_next;
    logic [2:0] token_out_q;
    logic       grant_q, deny_q, ack_q, err_q;
    logic       grant_next, deny_next, ack_next, err_next;

    assign gate.entry_grant = grant_q;
    assign gate.entry_deny  = deny_q;
    assign gate.exit_ack    = ack_q;
    assign gate.exit_err    = err_q;
    assign gate.token_out   = token_out_q;
    assign dec_pattern      = pattern;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // WAIT_REL only watches the request being served, so a held opposite request survives to IDLE.
    always_comb begin
        next_state = state;
        pick_exit  = 1'b0;
        case (state)
            IDLE: begin
                pick_exit = gate.exit_req && (EXIT_FIRST || !gate.entry_req);
                if (pick_exit)           next_state = DECODE;
                else if (gate.entry_req) next_state = ALLOC;
            end
            ALLOC, DECODE: next_state = RESP;
            RESP:          next_state = WAIT_REL;
            WAIT_REL: begin
                if (!(serve_exit ? gate.exit_req : gate.entry_req)) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        free_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!occupancy[i]) free_idx = 3'(i);
        end
    end

    // The pattern only steps when the lot empties, so no outstanding token is ever orphaned.
    always_comb begin
        occ_next     = occupancy;
        free_next    = free_count;
        pattern_next = pattern;
        result_next  = result;
        case (state)
            ALLOC: begin
                if (!full) begin
                    occ_next[free_idx] = 1'b1;
                    free_next          = free_count - 4'd1;
                    result_next        = RES_GRANT;
                end else begin
                    result_next = RES_DENY;
                end
            end
            DECODE: begin
                if (occupancy[dec_park_number]) begin
                    occ_next[dec_park_number] = 1'b0;
                    free_next                 = free_count + 4'd1;
                    result_next               = RES_ACK;
                    if (free_count == 4'd7) pattern_next = {pattern[1:0], pattern[2] ^ pattern[1]};
                end else begin
                    result_next = RES_ERR;
                end
            end
            default: ;
        endcase
        grant_next = (state == RESP) && (result == RES_GRANT);
        deny_next  = (state == RESP) && (result == RES_DENY);
        ack_next   = (state == RESP) && (result == RES_ACK);
        err_next   = (state == RESP) && (result == RES_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy   <= 8'h00;
            free_count  <= 4'd8;
            full        <= 1'b0;
            pattern     <= PATTERN_SEED;
            result      <= RES_GRANT;
            token_out_q <= 3'd0;
            dec_token   <= 3'd0;
            serve_exit  <= 1'b0;
            dec_exit    <= 1'b0;
            grant_q     <= 1'b0;
            deny_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            occupancy  <= occ_next;
            free_count <= free_next;
            full       <= (occ_next == 8'hFF);
            pattern    <= pattern_next;
            result     <= result_next;
            dec_exit   <= (next_state == DECODE);
            grant_q    <= grant_next;
            deny_q     <= deny_next;
            ack_q      <= ack_next;
            err_q      <= err_next;
            if (state == ALLOC && !full)           token_out_q <= free_idx ^ pattern;
            if (state == IDLE && next_state != IDLE) serve_exit <= pick_exit;
            if (state == IDLE && pick_exit)          dec_token  <= gate.exit_token;
        end
    end

endmodule

// File: tb/tb_park_slot_controller.sv
// Directed, table-driven bench for park_slot_controller with a behavioural decrypt (token ^ pattern).
module tb_park_slot_controller;

    localparam int K_GRANT = 0;
    localparam int K_DENY  = 1;
    localparam int K_ACK   = 2;
    localparam int K_ERR   = 3;

    typedef struct {
        logic       entry;
        logic       exitr;
        logic [2:0] tok;
        int         kind;
        logic [2:0] exp_token;
        logic [7:0] exp_occ;
        logic [3:0] exp_free;
        logic       exp_full;
        logic [2:0] exp_pattern;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dec_exit;
    logic [2:0] dec_token, dec_pattern, dec_park_number;
    logic [7:0] occupancy;
    logic [3:0] free_count;
    logic       full;
    int         assertions = 0;
    int         failures = 0;
    vec_t       vecs[11];

    park_slot_controller_if gate_if();

    park_slot_controller #(.PATTERN_SEED(3'b101), .EXIT_FIRST(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .gate            (gate_if),
        .dec_exit        (dec_exit),
        .dec_token       (dec_token),
        .dec_pattern     (dec_pattern),
        .dec_park_number (dec_park_number),
        .occupancy       (occupancy),
        .free_count      (free_count),
        .full            (full)
    );

    assign dec_park_number = dec_token ^ dec_pattern;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [3:0] pulses();
        return {gate_if.entry_grant, gate_if.entry_deny, gate_if.exit_ack, gate_if.exit_err};
    endfunction

    // Waits on negedges for the first response pulse; kind -1 means timeout, 4 means several pulses at once.
    task automatic waitResponse(output int kind, output int lat, output logic saw_dec_exit);
        kind = -1;
        lat = 0;
        saw_dec_exit = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            lat++;
            if (dec_exit === 1'b1) saw_dec_exit = 1'b1;
            if (pulses() != 4'b0000) begin
                case (pulses())
                    4'b1000: kind = K_GRANT;
                    4'b0100: kind = K_DENY;
                    4'b0010: kind = K_ACK;
                    4'b0001: kind = K_ERR;
                    default: kind = 4;
                endcase
                break;
            end
        end
        if (kind == -1) begin
            assertions++;
            failures++;
            $display("[TB] FAIL response_timeout: got no pulse, expected one within 12 cycles");
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int   kind, lat;
        logic saw;
        @(negedge clk);
        gate_if.entry_req  = v.entry;
        gate_if.exit_req   = v.exitr;
        gate_if.exit_token = v.tok;
        waitResponse(kind, lat, saw);
        gate_if.entry_req = 1'b0;
        gate_if.exit_req  = 1'b0;
        checkOutput($sformatf("vec%0d_kind", idx), 32'(kind), 32'(v.kind));
        checkOutput($sformatf("vec%0d_latency", idx), 32'(lat), 32'd3);
        checkOutput($sformatf("vec%0d_dec_exit_seen", idx), 32'(saw), 32'(v.exitr));
        if (v.exitr) checkOutput($sformatf("vec%0d_dec_token", idx), 32'(dec_token), 32'(v.tok));
        checkOutput($sformatf("vec%0d_token_out", idx), 32'(gate_if.token_out), 32'(v.exp_token));
        checkOutput($sformatf("vec%0d_occupancy", idx), 32'(occupancy), 32'(v.exp_occ));
        checkOutput($sformatf("vec%0d_free_count", idx), 32'(free_count), 32'(v.exp_free));
        checkOutput($sformatf("vec%0d_full", idx), 32'(full), 32'(v.exp_full));
        checkOutput($sformatf("vec%0d_pattern", idx), 32'(dec_pattern), 32'(v.exp_pattern));
        repeat (3) @(negedge clk);
        checkOutput($sformatf("vec%0d_quiet", idx), 32'(pulses()), 32'd0);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_occupancy"}, 32'(occupancy), 32'h00);
        checkOutput({tag, "_free_count"}, 32'(free_count), 32'd8);
        checkOutput({tag, "_full"}, 32'(full), 32'd0);
        checkOutput({tag, "_pattern"}, 32'(dec_pattern), 32'b101);
        checkOutput({tag, "_pulses"}, 32'(pulses()), 32'd0);
        checkOutput({tag, "_dec_exit"}, 32'(dec_exit), 32'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int   kind, lat;
        logic saw;

        gate_if.entry_req  = 1'b0;
        gate_if.exit_req   = 1'b0;
        gate_if.exit_token = 3'd0;

        vecs[0]  = '{1'b1, 1'b0, 3'd0,   K_GRANT, 3'b101, 8'h01, 4'd7, 1'b0, 3'b101};
        vecs[1]  = '{1'b1, 1'b0, 3'd0,   K_GRANT, 3'b100, 8'h03, 4'd6, 1'b0, 3'b101};
        vecs[2]  = '{1'b1, 1'b0, 3'd0,   K_GRANT, 3'b111, 8'h07, 4'd5, 1'b0, 3'b101};
        vecs[3]  = '{1'b1, 1'b0, 3'd0,   K_GRANT, 3'b110, 8'h0F, 4'd4, 1'b0, 3'b101};
        vecs[4]  = '{1'b1, 1'b0, 3'd0,   K_GRANT, 3'b001, 8'h1F, 4'd3, 1'b0, 3'b101};
        vecs[5]  = '{1'b1, 1'b0, 3'd0,   K_GRANT, 3'b000, 8'h3F, 4'd2, 1'b0, 3'b101};
        vecs[6]  = '{1'b1, 1'b0, 3'd0,   K_GRANT, 3'b011, 8'h7F, 4'd1, 1'b0, 3'b101};
        vecs[7]  = '{1'b1, 1'b0, 3'd0,   K_GRANT, 3'b010, 8'hFF, 4'd0, 1'b1, 3'b101};
        vecs[8]  = '{1'b1, 1'b0, 3'd0,   K_DENY,  3'b010, 8'hFF, 4'd0, 1'b1, 3'b101};
        vecs[9]  = '{1'b0, 1'b1, 3'b100, K_ACK,   3'b010, 8'hFD, 4'd1, 1'b0, 3'b101};
        vecs[10] = '{1'b0, 1'b1, 3'b100, K_ERR,   3'b010, 8'hFD, 4'd1, 1'b0, 3'b101};

        repeat (2) @(negedge clk);
        checkReset("reset");
        checkOutput("reset_token_out", 32'(gate_if.token_out), 32'd0);
        checkOutput("reset_dec_token", 32'(dec_token), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

        // Simultaneous requests: exit is served first, held entry follows once exit drops.
        @(negedge clk);
        gate_if.entry_req  = 1'b1;
        gate_if.exit_req   = 1'b1;
        gate_if.exit_token = 3'b101;
        waitResponse(kind, lat, saw);
        checkOutput("both_first_kind", 32'(kind), 32'(K_ACK));
        checkOutput("both_first_occupancy", 32'(occupancy), 32'hFC);
        gate_if.exit_req = 1'b0;
        waitResponse(kind, lat, saw);
        gate_if.entry_req = 1'b0;
        checkOutput("both_second_kind", 32'(kind), 32'(K_GRANT));
        checkOutput("both_second_token", 32'(gate_if.token_out), 32'b101);
        checkOutput("both_second_occupancy", 32'(occupancy), 32'hFD);
        repeat (3) @(negedge clk);

        // Emptying the lot advances the pattern; the next token uses it.
        doReset();
        checkReset("reset2");
        applyStimulus('{1'b1, 1'b0, 3'd0,   K_GRANT, 3'b101, 8'h01, 4'd7, 1'b0, 3'b101}, 20);
        applyStimulus('{1'b0, 1'b1, 3'b101, K_ACK,   3'b101, 8'h00, 4'd8, 1'b0, 3'b011}, 21);
        applyStimulus('{1'b1, 1'b0, 3'd0,   K_GRANT, 3'b011, 8'h01, 4'd7, 1'b0, 3'b011}, 22);

        // Reset during ALLOC aborts silently; the still-held request is served afterwards.
        doReset();
        @(negedge clk);
        gate_if.entry_req = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 checkReset("rst_alloc");
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_alloc_no_pulse", 32'(pulses()), 32'd0);
        end
        rst_n = 1'b1;
        waitResponse(kind, lat, saw);
        gate_if.entry_req = 1'b0;
        checkOutput("rst_alloc_kind", 32'(kind), 32'(K_GRANT));
        checkOutput("rst_alloc_token", 32'(gate_if.token_out), 32'b101);
        checkOutput("rst_alloc_occupancy", 32'(occupancy), 32'h01);
        repeat (3) @(negedge clk);

        // Reset during DECODE clears slot 0, so the held exit then finds it empty.
        gate_if.exit_req   = 1'b1;
        gate_if.exit_token = 3'b101;
        @(posedge clk);
        #1 checkOutput("rst_dec_in_decode", 32'(dec_exit), 32'd1);
        rst_n = 1'b0;
        #1 checkReset("rst_dec");
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst_dec_no_pulse", 32'(pulses()), 32'd0);
        end
        rst_n = 1'b1;
        waitResponse(kind, lat, saw);
        gate_if.exit_req = 1'b0;
        checkOutput("rst_dec_kind", 32'(kind), 32'(K_ERR));
        checkOutput("rst_dec_occupancy", 32'(occupancy), 32'h00);
        checkOutput("rst_dec_free_count", 32'(free_count), 32'd8);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
